pwm_read_scheduler: RTL and testbench



---
 rtl/pwm_read_scheduler.sv | 154 +++++++++++++++
 tb/tb_pwm_read_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_read_scheduler.sv
// Purpose : frame-paced read controller for the PWM sample FIFO; primes, reads once per frame, mutes on starvation.
// Latency : read strobe in slot RD_SLOT, data captured at end of RD_SLOT+1, presented on the edge ending slot PERIOD-1.
// Backpres: none; an empty FIFO at the sample slot turns that frame's read into a counted miss.
//
// Ports:
//   MCLK, MRSTN            clock, synchronous active-low reset
//   enable                 run request; low forces IDLE on the next edge
//   fifo_count/fifo_empty  FIFO read-side fill level and empty flag
//   fifo_rd_en             registered read strobe, one cycle per frame at most
//   fifo_dout/fifo_valid   read data, valid one cycle after fifo_rd_en
//   pwm_data/pwm_load/mute sample to the modulator, frame-start strobe, mute flag
//   slot_cnt/state         free-running slot index, FSM state (IDLE=0, PREFILL=1, RUN=2)
//   underrun_cnt           saturating total of missed reads
module pwm_read_scheduler #(
   parameter int              PERIOD      = 12,
   parameter int              RD_SLOT     = 9,
   parameter int              DW          = 4,
   parameter int              CW          = 11,
   parameter int              PREFILL     = 1024,
   parameter int              UNDER_LIMIT = 4,
   parameter logic [DW-1:0]   MUTE_CODE   = 4'd8
) (
   input  logic                      MCLK,
   input  logic                      MRSTN,
   input  logic                      enable,
   input  logic [CW-1:0]             fifo_count,
   input  logic                      fifo_empty,
   output logic                      fifo_rd_en,
   input  logic [DW-1:0]             fifo_dout,
   input  logic                      fifo_valid,
   output logic [DW-1:0]             pwm_data,
   output logic                      pwm_load,
   output logic [$clog2(PERIOD)-1:0] slot_cnt,
   output logic                      mute,
   output logic [1:0]                state,
   output logic [15:0]               underrun_cnt
);

   localparam int SW = $clog2(PERIOD);
   localparam int MW = $clog2(UNDER_LIMIT + 1);

   localparam logic [SW-1:0] LAST_SLOT   = SW'(PERIOD - 1);
   localparam logic [SW-1:0] SAMPLE_SLOT = SW'(RD_SLOT - 1);
   localparam logic [CW-1:0] FILL_LEVEL  = CW'(PREFILL);
   localparam logic [MW-1:0] MISS_LAST   = MW'(UNDER_LIMIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t          cur_st;
   state_t          nxt_st;
   logic [MW-1:0]   miss_cnt;
   logic [MW-1:0]   miss_nxt;
   logic            frame_end;
   logic            sample_slot;
   logic            rd_issue;
   logic            rd_miss;
   logic            rd_pend;
   logic            capture;
   logic            rd_ok;
   logic [DW-1:0]   hold;

   assign frame_end   = (slot_cnt == LAST_SLOT);
   assign sample_slot = (slot_cnt == SAMPLE_SLOT);

   // The empty flag is judged one slot ahead so the strobe itself can be registered.
   // Gating with enable keeps a disable in the sample slot from launching a read.
   assign rd_issue = (cur_st == ST_RUN) && enable && sample_slot && !fifo_empty;
   assign rd_miss  = (cur_st == ST_RUN) && enable && sample_slot &&  fifo_empty;

   // Only data answering our own strobe is accepted; stray valids are dropped.
   assign capture = rd_pend && fifo_valid;

   assign state = cur_st;

   always_comb begin
      nxt_st   = cur_st;
      miss_nxt = miss_cnt;
      unique case (cur_st)
         ST_IDLE: begin
            if (enable) nxt_st = ST_PREFILL;
         end
         ST_PREFILL: begin
            if (frame_end && (fifo_count >= FILL_LEVEL)) nxt_st = ST_RUN;
         end
         ST_RUN: begin
            if (rd_issue) begin
               miss_nxt = '0;
            end else if (rd_miss) begin
               if (miss_cnt >= MISS_LAST) begin
                  nxt_st   = ST_PREFILL;
                  miss_nxt = '0;
               end else begin
                  miss_nxt = miss_cnt + MW'(1);
               end
            end
         end
         default: nxt_st = ST_IDLE;
      endcase
      if (!enable) nxt_st = ST_IDLE;
      // Consecutive-miss tracking restarts on every entry into RUN.
      if (nxt_st != ST_RUN) miss_nxt = '0;
   end

   always_ff @(posedge MCLK) begin
      if (!MRSTN) begin
         cur_st       <= ST_IDLE;
         slot_cnt     <= '0;
         miss_cnt     <= '0;
         underrun_cnt <= '0;
         fifo_rd_en   <= 1'b0;
         rd_pend      <= 1'b0;
         hold         <= MUTE_CODE;
         rd_ok        <= 1'b0;
         pwm_data     <= MUTE_CODE;
         mute         <= 1'b1;
         pwm_load     <= 1'b0;
      end else begin
         cur_st   <= nxt_st;
         miss_cnt <= miss_nxt;
         slot_cnt <= frame_end ? '0 : slot_cnt + SW'(1);

         fifo_rd_en <= rd_issue;
         rd_pend    <= fifo_rd_en;

         // A read already in flight still lands even if RUN was just left.
         if (capture) hold <= fifo_dout;

         // rd_ok marks that hold carries data fetched during the current RUN stint.
         if (nxt_st != ST_RUN) begin
            rd_ok <= 1'b0;
         end else if (capture && (cur_st == ST_RUN)) begin
            rd_ok <= 1'b1;
         end

         if (rd_miss && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;

         pwm_load <= frame_end;
         if (frame_end) begin
            if ((cur_st == ST_RUN) && rd_ok) begin
               pwm_data <= hold;
               mute     <= 1'b0;
            end else begin
               pwm_data <= MUTE_CODE;
               mute     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_read_scheduler.sv
module tb_pwm_read_scheduler;

   localparam int PERIOD  = 12;
   localparam int RD_SLOT = 9;

   logic        MCLK = 1'b0;
   logic        MRSTN = 1'b0;
   logic        enable = 1'b0;
   logic [10:0] fifo_count = '0;
   logic        fifo_empty = 1'b1;
   logic        fifo_rd_en;
   logic [3:0]  fifo_dout = '0;
   logic        fifo_valid = 1'b0;
   logic [3:0]  pwm_data;
   logic        pwm_load;
   logic [3:0]  slot_cnt;
   logic        mute;
   logic [1:0]  state;
   logic [15:0] underrun_cnt;

   pwm_read_scheduler dut (
      .MCLK         (MCLK),
      .MRSTN        (MRSTN),
      .enable       (enable),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_dout    (fifo_dout),
      .fifo_valid   (fifo_valid),
      .pwm_data     (pwm_data),
      .pwm_load     (pwm_load),
      .slot_cnt     (slot_cnt),
      .mute         (mute),
      .state        (state),
      .underrun_cnt (underrun_cnt)
   );

   always #5 MCLK = ~MCLK;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected outcome of one frame, observed at slot 0 of the following frame.
   typedef struct {
      int          frame;
      logic [3:0]  data;
      logic        mute;
      logic [1:0]  st;
      logic [15:0] urun;
      int          rds;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   rd_seen = 0;
   bit   mon_on = 1'b1;

   // Monitor: pops one expectation per pwm_load, and polices read strobe placement.
   initial begin
      forever begin
         @(negedge MCLK);
         if (mon_on && MRSTN && (pwm_load === 1'b1)) begin
            check("load_slot", 32'(slot_cnt), 0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL load_unexpected: got pwm_load=1 expected no frame pending");
            end else begin
               mon_e = sb.pop_front();
               check($sformatf("f%0d_pwm_data", mon_e.frame), 32'(pwm_data), 32'(mon_e.data));
               check($sformatf("f%0d_mute", mon_e.frame), 32'(mute), 32'(mon_e.mute));
               check($sformatf("f%0d_state", mon_e.frame), 32'(state), 32'(mon_e.st));
               check($sformatf("f%0d_underrun", mon_e.frame), 32'(underrun_cnt), 32'(mon_e.urun));
               check($sformatf("f%0d_reads", mon_e.frame), 32'(rd_seen), 32'(mon_e.rds));
            end
            rd_seen = 0;
         end
         if (mon_on && (fifo_rd_en === 1'b1)) begin
            rd_seen++;
            check("rd_slot", 32'(slot_cnt), RD_SLOT);
         end
      end
   end

   // Drives one frame starting in slot 0; returns at slot 0 of the next frame.
   // off_lo..off_hi: slots with enable low. stray: slot of an unsolicited valid (-1 none).
   // probe: slot at which state is compared against probe_st (-1 none). sat: preload underrun_cnt.
   task automatic run_frame(
      input int f, input logic en, input int off_lo, input int off_hi,
      input logic [10:0] cnt, input logic empty, input logic [3:0] dout,
      input int stray, input int probe, input logic [1:0] probe_st, input bit sat,
      input logic [3:0] e_data, input logic e_mute, input logic [1:0] e_st,
      input logic [15:0] e_urun, input int e_rds);
      exp_t e;
      bit   resp;
      e.frame = f; e.data = e_data; e.mute = e_mute; e.st = e_st; e.urun = e_urun; e.rds = e_rds;
      sb.push_back(e);
      for (int s = 0; s < PERIOD; s++) begin
         resp       = (s == RD_SLOT + 1) && (e_rds != 0);
         enable     = en && !((s >= off_lo) && (s <= off_hi));
         fifo_count = cnt;
         fifo_empty = empty;
         fifo_valid = resp || (s == stray);
         fifo_dout  = resp ? dout : ((s == stray) ? 4'hE : 4'h0);
         @(negedge MCLK);
         if (s == probe) check($sformatf("f%0d_state_slot%0d", f, s), 32'(state), 32'(probe_st));
         if (sat && (s == 2)) begin
            force dut.underrun_cnt = 16'hFFFE;
            #1;
            release dut.underrun_cnt;
         end
         @(posedge MCLK);
         #1;
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rd_en"},    32'(fifo_rd_en),   0);
      check({tag, "_load"},     32'(pwm_load),     0);
      check({tag, "_pwm_data"}, 32'(pwm_data),     8);
      check({tag, "_mute"},     32'(mute),         1);
      check({tag, "_state"},    32'(state),        0);
      check({tag, "_slot"},     32'(slot_cnt),     0);
      check({tag, "_underrun"}, 32'(underrun_cnt), 0);
   endtask

   initial begin
      MRSTN = 1'b0;
      repeat (3) @(posedge MCLK);
      #1;
      check_reset("rst");
      MRSTN = 1'b1;

      //        f  en lo hi  cnt    emp dout stray probe pst sat | data mute st urun      rds
      run_frame(0, 1, 99, 99, 11'd1023, 0, 4'h0, -1, -1, 2'd0, 0, 4'h8, 1, 2'd1, 16'd0, 0);
      run_frame(1, 1, 99, 99, 11'd1023, 0, 4'h0, -1, -1, 2'd0, 0, 4'h8, 1, 2'd1, 16'd0, 0);
      run_frame(2, 1, 99, 99, 11'd1024, 0, 4'h0, -1,  5, 2'd1, 0, 4'h8, 1, 2'd2, 16'd0, 0);
      run_frame(3, 1, 99, 99, 11'd1024, 0, 4'h3, -1, -1, 2'd0, 0, 4'h3, 0, 2'd2, 16'd0, 1);
      run_frame(4, 1, 99, 99, 11'd1024, 0, 4'h5, -1, -1, 2'd0, 0, 4'h5, 0, 2'd2, 16'd0, 1);
      // single miss: sample repeats
      run_frame(5, 1, 99, 99, 11'd1024, 1, 4'h0, -1, -1, 2'd0, 0, 4'h5, 0, 2'd2, 16'd1, 0);
      run_frame(6, 1, 99, 99, 11'd1024, 0, 4'h6, -1, -1, 2'd0, 0, 4'h6, 0, 2'd2, 16'd1, 1);
      // four consecutive misses: fourth drops to PREFILL before the boundary
      run_frame(7, 1, 99, 99, 11'd1024, 1, 4'h0, -1, -1, 2'd0, 0, 4'h6, 0, 2'd2, 16'd2, 0);
      run_frame(8, 1, 99, 99, 11'd1024, 1, 4'h0, -1, -1, 2'd0, 0, 4'h6, 0, 2'd2, 16'd3, 0);
      run_frame(9, 1, 99, 99, 11'd1024, 1, 4'h0, -1, -1, 2'd0, 0, 4'h6, 0, 2'd2, 16'd4, 0);
      run_frame(10, 1, 99, 99, 11'd1000, 1, 4'h0, -1, 10, 2'd1, 0, 4'h8, 1, 2'd1, 16'd5, 0);
      run_frame(11, 1, 99, 99, 11'd1024, 0, 4'h0, -1, -1, 2'd0, 0, 4'h8, 1, 2'd2, 16'd5, 0);
      // first RUN frame is a miss: stale hold must not be shown
      run_frame(12, 1, 99, 99, 11'd1024, 1, 4'h0, -1, -1, 2'd0, 0, 4'h8, 1, 2'd2, 16'd6, 0);
      run_frame(13, 1, 99, 99, 11'd1024, 0, 4'h9, -1, -1, 2'd0, 0, 4'h9, 0, 2'd2, 16'd6, 1);
      // stray valids: on a miss frame, then ahead of a real read
      run_frame(14, 1, 99, 99, 11'd1024, 1, 4'h0, 10, -1, 2'd0, 0, 4'h9, 0, 2'd2, 16'd7, 0);
      run_frame(15, 1, 99, 99, 11'd1024, 0, 4'hA,  3, -1, 2'd0, 0, 4'hA, 0, 2'd2, 16'd7, 1);
      // disable during the read slot: read completes, then IDLE and mute
      run_frame(16, 1,  9, 11, 11'd1024, 0, 4'hB, -1, 11, 2'd0, 0, 4'h8, 1, 2'd0, 16'd7, 1);
      // one-cycle enable drop: IDLE visible, then PREFILL, then RUN at boundary
      run_frame(17, 1,  5,  5, 11'd1024, 0, 4'h0, -1,  6, 2'd0, 0, 4'h8, 1, 2'd2, 16'd7, 0);
      run_frame(18, 1, 99, 99, 11'd1024, 0, 4'hC, -1, -1, 2'd0, 0, 4'hC, 0, 2'd2, 16'd7, 1);
      // saturation: preload 0xFFFE, then two misses
      run_frame(19, 1, 99, 99, 11'd1024, 1, 4'h0, -1, -1, 2'd0, 1, 4'hC, 0, 2'd2, 16'hFFFF, 0);
      run_frame(20, 1, 99, 99, 11'd1024, 1, 4'h0, -1, -1, 2'd0, 0, 4'hC, 0, 2'd2, 16'hFFFF, 0);
      run_frame(21, 1, 99, 99, 11'd1024, 0, 4'hD, -1, -1, 2'd0, 0, 4'hD, 0, 2'd2, 16'hFFFF, 1);

      @(negedge MCLK);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 0);

      // Mid-frame reset with a valid pending: everything returns to reset values.
      repeat (4) @(posedge MCLK);
      #1;
      mon_on     = 1'b0;
      enable     = 1'b0;
      fifo_valid = 1'b1;
      fifo_dout  = 4'h1;
      MRSTN      = 1'b0;
      @(posedge MCLK);
      #1;
      MRSTN      = 1'b1;
      fifo_valid = 1'b0;
      check_reset("midrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
